aq_axis_dwidth_down: RTL

- Downstream neighbour of the AXIS async FIFO, in the read-side clock domain.
- Consumes the wide FIFO output stream and serialises each word into RATIO narrow beats, least-significant lane first.
- The FIFO master side carries no TLAST, so this block regenerates TLAST from a programmed packet length counted in output beats.

---
 rtl/aq_axis_dwidth_down.sv | 138 +++++++++++++
 1 files changed

// File: rtl/aq_axis_dwidth_down.sv
// Serialises each wide AXIS word into RATIO narrow beats (lane 0 first) and regenerates TLAST from PKT_LEN.
// Latency: 1 cycle from input acceptance to first output beat; sustained 1 output beat per cycle.
// Backpressure: S_AXIS_TREADY only while the hold register is empty or its last lane leaves; outputs hold while stalled.
module aq_axis_dwidth_down #(
  parameter int IN_WIDTH  = 64,
  parameter int RATIO     = 2,
  parameter int LEN_WIDTH = 16
) (
  input  logic                          ACLK,
  input  logic                          RST_N,
  input  logic                          S_AXIS_TVALID,
  output logic                          S_AXIS_TREADY,
  input  logic [IN_WIDTH-1:0]           S_AXIS_TDATA,
  output logic                          M_AXIS_TVALID,
  input  logic                          M_AXIS_TREADY,
  output logic                          M_AXIS_TLAST,
  output logic [IN_WIDTH/RATIO-1:0]     M_AXIS_TDATA,
  input  logic                          ENABLE,
  input  logic [LEN_WIDTH-1:0]          PKT_LEN,
  output logic                          PKT_DONE,
  output logic                          BUSY
);

  localparam int OUT_WIDTH = IN_WIDTH / RATIO;
  localparam int LANE_W    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [LANE_W-1:0]    LANE_LAST = LANE_W'(RATIO - 1);
  localparam logic [LEN_WIDTH-1:0] CNT_MAX   = {LEN_WIDTH{1'b1}};

  logic                 rdy_en_q;
  logic [IN_WIDTH-1:0]  hold_q, hold_d;
  logic                 hold_vld_q, hold_vld_d;
  logic [LANE_W-1:0]    lane_q, lane_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] eff_len;
  logic                 m_tvalid_q, m_tvalid_d;
  logic                 m_tlast_q, m_tlast_d;
  logic [OUT_WIDTH-1:0] m_tdata_q, m_tdata_d;
  logic                 pkt_done_q, pkt_done_d;
  logic                 busy_q, busy_d;

  logic m_xfer;
  logic last_lane;
  logic s_ready;
  logic s_load;

  assign m_xfer    = m_tvalid_q & M_AXIS_TREADY;
  assign last_lane = (lane_q == LANE_LAST);
  // A new word may land in the same cycle the final lane leaves, so there is no bubble between words.
  assign s_ready   = rdy_en_q & (~hold_vld_q | (m_xfer & last_lane));
  assign s_load    = S_AXIS_TVALID & s_ready;

  assign S_AXIS_TREADY = s_ready;
  assign M_AXIS_TVALID = m_tvalid_q;
  assign M_AXIS_TLAST  = m_tlast_q;
  assign M_AXIS_TDATA  = m_tdata_q;
  assign PKT_DONE      = pkt_done_q;
  assign BUSY          = busy_q;

  // Hold register and lane pointer: advance on beat transfer, reload on word acceptance.
  always_comb begin
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    lane_d     = lane_q;
    if (m_xfer) begin
      if (last_lane) hold_vld_d = 1'b0;
      else           lane_d     = lane_q + LANE_W'(1);
    end
    if (s_load) begin
      hold_d     = S_AXIS_TDATA;
      hold_vld_d = 1'b1;
      lane_d     = '0;
    end
  end

  // Packet beat counter and length latch; a zero length saturates the counter instead of wrapping.
  always_comb begin
    cnt_d      = cnt_q;
    len_d      = len_q;
    pkt_done_d = 1'b0;
    if (m_xfer) begin
      if (cnt_q == '0) len_d = PKT_LEN;
      if (m_tlast_q) begin
        cnt_d      = '0;
        pkt_done_d = 1'b1;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + LEN_WIDTH'(1);
      end
    end
    busy_d = (cnt_d != '0);
  end

  // Registered output beat: frozen while stalled, otherwise the next lane, gated by ENABLE at packet boundaries.
  always_comb begin
    eff_len    = (cnt_d == '0) ? PKT_LEN : len_d;
    m_tvalid_d = m_tvalid_q;
    m_tlast_d  = m_tlast_q;
    m_tdata_d  = m_tdata_q;
    if (!(m_tvalid_q && !M_AXIS_TREADY)) begin
      m_tvalid_d = hold_vld_d & ((cnt_d != '0) | ENABLE);
      m_tlast_d  = (eff_len != '0) & (cnt_d == eff_len - LEN_WIDTH'(1));
      m_tdata_d  = hold_d[OUT_WIDTH-1:0];
      for (int i = 0; i < RATIO; i++) begin
        if (lane_d == LANE_W'(i)) m_tdata_d = hold_d[i*OUT_WIDTH +: OUT_WIDTH];
      end
    end
  end

  // State and output registers; ready enable comes up one cycle after reset release.
  always_ff @(posedge ACLK or negedge RST_N) begin
    if (!RST_N) begin
      rdy_en_q   <= 1'b0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      lane_q     <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      m_tdata_q  <= '0;
      pkt_done_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rdy_en_q   <= 1'b1;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      lane_q     <= lane_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      m_tvalid_q <= m_tvalid_d;
      m_tlast_q  <= m_tlast_d;
      m_tdata_q  <= m_tdata_d;
      pkt_done_q <= pkt_done_d;
      busy_q     <= busy_d;
    end
  end

endmodule
